// File: rtl/sap2_pkg.sv
// sap2_pkg: opcodes, microsequencer state encoding and instruction field positions.
package sap2_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_B,
        S_EXEC1,
        S_EXEC2,
        S_EXEC3,
        S_HALT
    } state_t;

    // Opcode occupies the top nibble; the immediate is everything below it.
    function automatic int opc_lsb(input int data_w);
        return data_w - 4;
    endfunction

    function automatic int imm_msb(input int data_w);
        return data_w - 5;
    endfunction

endpackage

// File: rtl/sap2_ram.sv
// sap2_ram: program/data store, combinational read port and synchronous write port.
import sap2_pkg::*;

module sap2_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rd
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Contents are deliberately not reset so a loaded program survives clr.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    assign rd = mem[ra];

endmodule

// File: rtl/sap2_core.sv
// sap2_core: parametrised SAP-class CPU with internal RAM, host load port and microsequencer.
// Carry/zero flags and conditional jumps are built only when SAP2_FLAGS_EN is defined.
import sap2_pkg::*;

module sap2_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              halted,
    output logic              carry,
    output logic              zero
);
    localparam int OPC_LSB = opc_lsb(DATA_W);
    localparam int IMM_MSB = imm_msb(DATA_W);

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, mar;
    logic [DATA_W-1:0] ir, acc, b_reg, out_r;
    logic [DATA_W-1:0] ram_rd, ram_wd, b_op, sum, imm;
    logic [ADDR_W-1:0] ram_wa, oprnd;
    logic [3:0]        opc;
    logic              ram_we, is_sub, take_jmp, mem_op;

    assign opc    = ir[DATA_W-1:OPC_LSB];
    assign oprnd  = ir[ADDR_W-1:0];
    assign imm    = DATA_W'(ir[IMM_MSB:0]);
    assign mem_op = (opc == OP_LDA) || (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_STA);
    assign is_sub = (opc == OP_SUB);
    assign b_op   = is_sub ? ~b_reg : b_reg;

`ifdef SAP2_FLAGS_EN
    logic sum_co, carry_r, zero_r;

    assign {sum_co, sum} = {1'b0, acc} + {1'b0, b_op} + {{DATA_W{1'b0}}, is_sub};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
        end else if (state == S_EXEC3 && run) begin
            carry_r <= sum_co;
            zero_r  <= (sum == '0);
        end
    end

    assign carry = carry_r;
    assign zero  = zero_r;
`else
    assign sum   = acc + b_op + DATA_W'(is_sub);
    assign carry = 1'b0;
    assign zero  = 1'b0;
`endif

    // With flags tied low JC/JZ never branch, so they fall through as NOPs.
    always_comb begin
        take_jmp = 1'b0;
        case (opc)
            OP_JMP:  take_jmp = 1'b1;
            OP_JC:   take_jmp = carry;
            OP_JZ:   take_jmp = zero;
            default: take_jmp = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (run) state_n = S_FETCH_A;
            S_FETCH_A: state_n = S_FETCH_B;
            S_FETCH_B: state_n = S_EXEC1;
            S_EXEC1: begin
                if (mem_op)               state_n = S_EXEC2;
                else if (opc == OP_HLT)   state_n = S_HALT;
                else                      state_n = S_FETCH_A;
            end
            S_EXEC2:   state_n = (opc == OP_ADD || opc == OP_SUB) ? S_EXEC3 : S_FETCH_A;
            S_EXEC3:   state_n = S_FETCH_A;
            S_HALT:    if (!run) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
        if (!run && state != S_HALT) state_n = S_IDLE;
    end

    // Datapath updates are gated by run so an abandoned instruction leaves no trace.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc        <= '0;
            mar       <= '0;
            ir        <= '0;
            acc       <= '0;
            b_reg     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    pc    <= '0;
                    mar   <= '0;
                    ir    <= '0;
                    acc   <= '0;
                    b_reg <= '0;
                end
                S_FETCH_A: if (run) mar <= pc;
                S_FETCH_B: if (run) begin
                    ir <= ram_rd;
                    pc <= pc + ADDR_W'(1);
                end
                S_EXEC1: if (run) begin
                    if (mem_op) mar <= oprnd;
                    case (opc)
                        OP_LDI: acc <= imm;
                        OP_JMP, OP_JC, OP_JZ: if (take_jmp) pc <= oprnd;
                        OP_OUT: begin
                            out_r     <= acc;
                            out_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_EXEC2: if (run) begin
                    if (opc == OP_LDA) acc <= ram_rd;
                    if (opc == OP_ADD || opc == OP_SUB) b_reg <= ram_rd;
                end
                S_EXEC3: if (run) acc <= sum;
                default: ;
            endcase
        end
    end

    // Host loads own the write port while stopped; STA owns it in EXEC2.
    always_comb begin
        ram_we = 1'b0;
        ram_wa = prog_addr;
        ram_wd = prog_data;
        if (state == S_IDLE || state == S_HALT) begin
            ram_we = prog_we;
        end else if (state == S_EXEC2 && opc == OP_STA && run) begin
            ram_we = 1'b1;
            ram_wa = mar;
            ram_wd = acc;
        end
    end

    sap2_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk (clk),
        .we  (ram_we),
        .wa  (ram_wa),
        .wd  (ram_wd),
        .ra  (mar),
        .rd  (ram_rd)
    );

    assign out    = out_r;
    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_sap2_core.sv
// tb_sap2_core: randomized and directed checks of sap2_core against an instruction-level model.
`timescale 1ns/1ps
module tb_sap2_core;

`ifdef SAP2_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] cyc;
        logic [7:0]  val;
        logic        c;
        logic        z;
    } ev_t;

    logic       clk = 1'b0, clr = 1'b0, run = 1'b0, prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic [7:0] out;
    logic       out_valid, halted, carry, zero;

    logic        run12 = 1'b0, we12 = 1'b0;
    logic [7:0]  addr12 = '0;
    logic [11:0] data12 = '0;
    logic [11:0] w_out;
    logic        w_out_valid, w_halted, w_carry, w_zero;

    int checks = 0, errors = 0;

    logic [7:0] img [16];
    ev_t        m_ev[$], d_ev[$];
    int         m_halt_cyc, d_halt_cyc;
    logic       m_c = 1'b0, m_z = 1'b0;
    logic [7:0] m_out = '0;

    sap2_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .clr(clr), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .out(out), .out_valid(out_valid), .halted(halted),
        .carry(carry), .zero(zero)
    );

    sap2_core #(.DATA_W(12), .ADDR_W(8)) dut12 (
        .clk(clk), .clr(clr), .run(run12), .prog_we(we12), .prog_addr(addr12),
        .prog_data(data12), .out(w_out), .out_valid(w_out_valid), .halted(w_halted),
        .carry(w_carry), .zero(w_zero)
    );

    always #5 clk = ~clk;

    // Instruction-level reference: each instruction takes its documented cycle count,
    // events are recorded at the cycle the instruction completes.
    task automatic model_run(input int budget);
        logic [7:0] m [16];
        logic [7:0] acc;
        int pc, cyc, n, op, a, t;
        m = img; pc = 0; cyc = 0; acc = '0;
        m_ev.delete(); m_halt_cyc = -1;
        forever begin
            op = int'(m[pc][7:4]);
            a  = int'(m[pc][3:0]);
            n  = (op == 1 || op == 4) ? 4 : (op == 2 || op == 3) ? 5 : 3;
            if (cyc + n > budget) break;
            cyc += n;
            pc = (pc + 1) % 16;
            case (op)
                1: acc = m[a];
                2: begin
                    t = int'(acc) + int'(m[a]);
                    acc = 8'(t % 256);
                    if (FLAGS) begin m_c = (t > 255); m_z = (acc == 0); end
                end
                3: begin
                    t = int'(acc) - int'(m[a]);
                    acc = 8'((t + 256) % 256);
                    if (FLAGS) begin m_c = (t >= 0); m_z = (acc == 0); end
                end
                4: m[a] = acc;
                5: acc = 8'(a);
                6: pc = a;
                7: if (m_c) pc = a;
                8: if (m_z) pc = a;
                14: begin m_out = acc; m_ev.push_back({16'(cyc), acc, m_c, m_z}); end
                15: begin m_halt_cyc = cyc; break; end
                default: ;
            endcase
        end
    endtask

    task automatic load_prog(input logic [7:0] p [16]);
        for (int i = 0; i < 16; i++) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = p[i];
            @(posedge clk); #1;
            img[i] = p[i];
        end
        prog_we = 1'b0;
    endtask

    task automatic dut_run(input int budget, input bit poke);
        d_ev.delete(); d_halt_cyc = -1;
        run = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (poke && n == 2) begin prog_we = 1'b1; prog_addr = 4'h0; prog_data = 8'hF0; end
            if (out_valid) d_ev.push_back({16'(n), out, carry, zero});
            if (halted) begin d_halt_cyc = n; break; end
        end
        prog_we = 1'b0;
    endtask

    task automatic stop();
        run = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({out, out_valid, halted, carry, zero} !== 12'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 000", {out, out_valid, halted, carry, zero});
        end
        clr = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_out();
        logic [7:0] p [16] = '{8'h19, 8'h2A, 8'hE0, 8'hF0, 0, 0, 0, 0, 0, 8'h1C, 8'h0E, 0, 0, 0, 0, 0};
        load_prog(p);
        model_run(60);
        dut_run(60, 1'b0);
        checks++; if (d_halt_cyc !== 15) begin errors++; $display("FAIL add_halt_cycle got %0d exp 15", d_halt_cyc); end
        checks++; if (d_ev.size() != 1) begin errors++; $display("FAIL add_pulses got %0d exp 1", d_ev.size()); end
        if (d_ev.size() > 0) begin
            checks++; if (d_ev[0].val !== 8'h2A) begin errors++; $display("FAIL add_out got %h exp 2a", d_ev[0].val); end
        end
        foreach (m_ev[i]) if (i < d_ev.size()) begin
            checks++; if (d_ev[i] !== m_ev[i]) begin errors++; $display("FAIL add_ev%0d got %h exp %h", i, d_ev[i], m_ev[i]); end
        end
        stop();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_release got %b exp 0", halted); end
    endtask

    task automatic test_reset_mid_add();
        run = 1'b1;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1; clr = 1'b0; run = 1'b0; m_c = 1'b0; m_z = 1'b0; m_out = '0;
        #2;
        checks++;
        if ({out, out_valid, halted, carry, zero} !== 12'h0) begin
            errors++;
            $display("FAIL midadd_reset got %h exp 000", {out, out_valid, halted, carry, zero});
        end
        #1; clr = 1'b1;
        @(posedge clk); #1;
        model_run(60);
        dut_run(60, 1'b0);
        checks++; if (d_halt_cyc !== m_halt_cyc) begin errors++; $display("FAIL rerun_halt got %0d exp %0d", d_halt_cyc, m_halt_cyc); end
        checks++; if (out !== 8'h2A) begin errors++; $display("FAIL rerun_out got %h exp 2a", out); end
        stop();
    endtask

    task automatic test_sub();
        logic [7:0] p [16] = '{8'h19, 8'h39, 8'hE0, 8'h51, 8'h3A, 8'hE0, 8'hF0, 0, 0, 8'h33, 8'h02, 0, 0, 0, 0, 0};
        load_prog(p);
        model_run(80);
        dut_run(80, 1'b0);
        checks++; if (d_ev.size() != 2) begin errors++; $display("FAIL sub_pulses got %0d exp 2", d_ev.size()); end
        if (d_ev.size() == 2) begin
            checks++;
            if ({d_ev[0].val, d_ev[0].c, d_ev[0].z} !== {8'h00, FLAGS, FLAGS}) begin
                errors++; $display("FAIL sub_equal got %h exp %h", {d_ev[0].val, d_ev[0].c, d_ev[0].z}, {8'h00, FLAGS, FLAGS});
            end
            checks++;
            if ({d_ev[1].val, d_ev[1].c, d_ev[1].z} !== {8'hFF, 2'b00}) begin
                errors++; $display("FAIL sub_borrow got %h exp 3fc", {d_ev[1].val, d_ev[1].c, d_ev[1].z});
            end
        end
        foreach (m_ev[i]) if (i < d_ev.size()) begin
            checks++; if (d_ev[i] !== m_ev[i]) begin errors++; $display("FAIL sub_ev%0d got %h exp %h", i, d_ev[i], m_ev[i]); end
        end
        stop();
    endtask

    task automatic test_countdown();
        logic [7:0] p [16] = '{8'h53, 8'h4F, 8'hE0, 8'h3E, 8'h87, 8'h62, 0, 8'hF0, 0, 0, 0, 0, 0, 0, 8'h01, 0};
        load_prog(p);
        model_run(120);
        dut_run(120, 1'b0);
        checks++; if ((d_halt_cyc >= 0) !== FLAGS) begin errors++; $display("FAIL loop_halts got %0d exp %0d", d_halt_cyc >= 0, FLAGS); end
        checks++; if (d_ev.size() < 3) begin errors++; $display("FAIL loop_count got %0d exp >=3", d_ev.size()); end
        if (d_ev.size() >= 3) begin
            checks++;
            if ({d_ev[0].val, d_ev[1].val, d_ev[2].val} !== 24'h030201) begin
                errors++; $display("FAIL loop_values got %h exp 030201", {d_ev[0].val, d_ev[1].val, d_ev[2].val});
            end
        end
        checks++; if (d_ev.size() != m_ev.size()) begin errors++; $display("FAIL loop_model_count got %0d exp %0d", d_ev.size(), m_ev.size()); end
        foreach (m_ev[i]) if (i < d_ev.size()) begin
            checks++; if (d_ev[i] !== m_ev[i]) begin errors++; $display("FAIL loop_ev%0d got %h exp %h", i, d_ev[i], m_ev[i]); end
        end
        stop();
    endtask

    // JMP 15 / OUT at 15 / wrap to 0: the pulse cadence exposes PC wrap and ignored loads.
    task automatic test_pc_wrap();
        logic [7:0] p [16] = '{8'h6F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hE0};
        load_prog(p);
        model_run(60);
        dut_run(60, 1'b1);
        checks++; if (d_halt_cyc !== -1) begin errors++; $display("FAIL wrap_halt got %0d exp -1", d_halt_cyc); end
        checks++; if (d_ev.size() != 10) begin errors++; $display("FAIL wrap_pulses got %0d exp 10", d_ev.size()); end
        foreach (m_ev[i]) if (i < d_ev.size()) begin
            checks++; if (d_ev[i] !== m_ev[i]) begin errors++; $display("FAIL wrap_ev%0d got %h exp %h", i, d_ev[i], m_ev[i]); end
        end
        stop();
    endtask

    task automatic test_random();
        int ops [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 14, 15, 11};
        logic [7:0] p [16];
        for (int r = 0; r < 6; r++) begin
            foreach (p[i]) p[i] = (i < 10) ? {4'(ops[$urandom_range(0, 11)]), 4'($urandom_range(0, 15))}
                                           : 8'($urandom_range(0, 255));
            load_prog(p);
            model_run(150);
            dut_run(150, 1'b0);
            checks++; if (d_halt_cyc !== m_halt_cyc) begin errors++; $display("FAIL rnd%0d_halt got %0d exp %0d", r, d_halt_cyc, m_halt_cyc); end
            checks++; if (d_ev.size() != m_ev.size()) begin errors++; $display("FAIL rnd%0d_pulses got %0d exp %0d", r, d_ev.size(), m_ev.size()); end
            foreach (m_ev[i]) if (i < d_ev.size()) begin
                checks++; if (d_ev[i] !== m_ev[i]) begin errors++; $display("FAIL rnd%0d_ev%0d got %h exp %h", r, i, d_ev[i], m_ev[i]); end
            end
            checks++;
            if ({out, carry, zero} !== {m_out, m_c, m_z}) begin
                errors++; $display("FAIL rnd%0d_final got %h exp %h", r, {out, carry, zero}, {m_out, m_c, m_z});
            end
            stop();
        end
    endtask

    task automatic test_wide();
        logic [11:0] p [9] = '{12'h110, 12'h211, 12'hE00, 12'h5AB, 12'h4FF, 12'h500, 12'h1FF, 12'hE00, 12'hF00};
        int          q_cyc[$];
        logic [13:0] q_ev[$];
        int          hc = -1;
        for (int i = 0; i < 11; i++) begin
            we12 = 1'b1;
            addr12 = (i < 9) ? 8'(i) : 8'(16 + i - 9);
            data12 = (i < 9) ? p[i] : ((i == 9) ? 12'hFFF : 12'h001);
            @(posedge clk); #1;
        end
        we12 = 1'b0;
        run12 = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (w_out_valid) begin q_cyc.push_back(n); q_ev.push_back({w_out, w_carry, w_zero}); end
            if (w_halted) begin hc = n; break; end
        end
        checks++; if (hc !== 32) begin errors++; $display("FAIL wide_halt got %0d exp 32", hc); end
        checks++; if (q_ev.size() != 2) begin errors++; $display("FAIL wide_pulses got %0d exp 2", q_ev.size()); end
        if (q_ev.size() == 2) begin
            checks++; if (q_ev[0] !== {12'h000, FLAGS, FLAGS}) begin errors++; $display("FAIL wide_add got %h exp %h", q_ev[0], {12'h000, FLAGS, FLAGS}); end
            checks++; if (q_ev[1] !== {12'h0AB, FLAGS, FLAGS}) begin errors++; $display("FAIL wide_sta got %h exp %h", q_ev[1], {12'h0AB, FLAGS, FLAGS}); end
            checks++; if (q_cyc[0] !== 12) begin errors++; $display("FAIL wide_out_cycle got %0d exp 12", q_cyc[0]); end
        end
        run12 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add_out();
        test_reset_mid_add();
        test_sub();
        test_countdown();
        test_pc_wrap();
        test_random();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
